// File: rtl/uart_hasti_bridge_pkg.sv
// Shared HASTI encodings, bridge command codes and FSM state type for the
// UART-to-HASTI debug bridge.
`ifndef HASTI_ADDR_WIDTH
`define HASTI_ADDR_WIDTH 32
`endif
`ifndef HASTI_BUS_WIDTH
`define HASTI_BUS_WIDTH 32
`endif
`ifndef HASTI_SIZE_WIDTH
`define HASTI_SIZE_WIDTH 3
`endif
`ifndef HASTI_BURST_WIDTH
`define HASTI_BURST_WIDTH 3
`endif
`ifndef HASTI_PROT_WIDTH
`define HASTI_PROT_WIDTH 4
`endif
`ifndef HASTI_TRANS_WIDTH
`define HASTI_TRANS_WIDTH 2
`endif

package uart_hasti_bridge_pkg;

    localparam int unsigned ADDR_W = `HASTI_ADDR_WIDTH;
    localparam int unsigned BUS_W  = `HASTI_BUS_WIDTH;

    localparam logic [`HASTI_TRANS_WIDTH-1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [`HASTI_TRANS_WIDTH-1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [`HASTI_SIZE_WIDTH-1:0]  HSIZE_WORD    = 3'b010;
    localparam logic [`HASTI_BURST_WIDTH-1:0] HBURST_SINGLE = 3'b000;
    localparam logic [`HASTI_PROT_WIDTH-1:0]  HPROT_DATA_PRIV = 4'b0011;

    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_BUS_A = 3'd3,
        ST_BUS_D = 3'd4,
        ST_RESP  = 3'd5
    } state_e;

    // Little-endian byte lane select used when serialising read data.
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/uart_hasti_bridge.sv
// UART byte-stream to single-word HASTI master: decodes write/read frames from
// the RX FIFO, runs one bus transfer and streams the result into the TX FIFO.
module uart_hasti_bridge
    import uart_hasti_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  ACK_BYTE       = 8'hA5,
    parameter logic [7:0]  ERR_BYTE       = 8'hEE
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [7:0]                     rx_data,
    input  logic                           rx_valid,
    output logic                           rx_pop,
    output logic [7:0]                     tx_data,
    output logic                           tx_push,
    input  logic                           tx_full,
    output logic [`HASTI_ADDR_WIDTH-1:0]   haddr,
    output logic                           hwrite,
    output logic [`HASTI_SIZE_WIDTH-1:0]   hsize,
    output logic [`HASTI_BURST_WIDTH-1:0]  hburst,
    output logic                           hmastlock,
    output logic [`HASTI_PROT_WIDTH-1:0]   hprot,
    output logic [`HASTI_TRANS_WIDTH-1:0]  htrans,
    output logic [`HASTI_BUS_WIDTH-1:0]    hwdata,
    input  logic [`HASTI_BUS_WIDTH-1:0]    hrdata,
    input  logic                           hready,
    input  logic                           hresp
);

    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit          TO_EN = (TIMEOUT_CYCLES != 32'd0);
    localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(TIMEOUT_CYCLES - 32'd1) : '0;
    localparam logic [ADDR_W-1:0] ADDR_ALIGN_MASK = ~(ADDR_W'(32'd3));

    state_e              state_q,    state_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [BUS_W-1:0]    data_q,     data_d;
    logic                is_wr_q,    is_wr_d;
    logic                err_q,      err_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [TO_W-1:0]     to_cnt_q,   to_cnt_d;

    logic                rx_pop_s;
    logic                tx_push_s;
    logic [7:0]          tx_byte_s;
    logic                resp_last_s;

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            is_wr_q    <= 1'b0;
            err_q      <= 1'b0;
            byte_cnt_q <= 2'd0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            is_wr_q    <= is_wr_d;
            err_q      <= err_d;
            byte_cnt_q <= byte_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    // Writes and errored reads answer with one byte, good reads with four.
    always_comb begin
        if (is_wr_q || err_q) begin
            resp_last_s = (byte_cnt_q == 2'd0);
        end else begin
            resp_last_s = (byte_cnt_q == 2'd3);
        end
    end

    // Next-state, frame assembly, bus sequencing and response serialisation.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        is_wr_d    = is_wr_q;
        err_d      = err_q;
        byte_cnt_d = byte_cnt_q;
        to_cnt_d   = to_cnt_q;
        rx_pop_s   = 1'b0;
        tx_push_s  = 1'b0;
        tx_byte_s  = 8'h00;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    rx_pop_s = 1'b1;
                    if ((rx_data == CMD_WR) || (rx_data == CMD_RD)) begin
                        is_wr_d    = (rx_data == CMD_WR);
                        state_d    = ST_ADDR;
                        byte_cnt_d = 2'd0;
                        to_cnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ADDR, ST_WDATA: begin
                if (rx_valid) begin
                    // A byte arriving on the expiry cycle still counts.
                    rx_pop_s   = 1'b1;
                    to_cnt_d   = '0;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (state_q == ST_ADDR) begin
                        addr_d = {rx_data, addr_q[ADDR_W-1:8]};
                    end else begin
                        data_d = {rx_data, data_q[BUS_W-1:8]};
                    end
                    if (byte_cnt_q == 2'd3) begin
                        if ((state_q == ST_ADDR) && is_wr_q) begin
                            state_d = ST_WDATA;
                        end else begin
                            state_d = ST_BUS_A;
                            err_d   = 1'b0;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
                    state_d  = ST_IDLE;
                    to_cnt_d = '0;
                end else if (TO_EN) begin
                    to_cnt_d = to_cnt_q + TO_W'(32'd1);
                end else begin
                    to_cnt_d = '0;
                end
            end

            ST_BUS_A: begin
                if (hready) begin
                    state_d = ST_BUS_D;
                end else begin
                    state_d = ST_BUS_A;
                end
            end

            ST_BUS_D: begin
                if (hready) begin
                    err_d      = hresp;
                    state_d    = ST_RESP;
                    byte_cnt_d = 2'd0;
                    if (!is_wr_q) begin
                        data_d = hrdata;
                    end else begin
                        data_d = data_q;
                    end
                end else begin
                    state_d = ST_BUS_D;
                end
            end

            ST_RESP: begin
                if (!tx_full) begin
                    tx_push_s = 1'b1;
                    if (err_q) begin
                        tx_byte_s = ERR_BYTE;
                    end else if (is_wr_q) begin
                        tx_byte_s = ACK_BYTE;
                    end else begin
                        tx_byte_s = word_byte(data_q, byte_cnt_q);
                    end
                    if (resp_last_s) begin
                        state_d    = ST_IDLE;
                        byte_cnt_d = 2'd0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end else begin
                    state_d = ST_RESP;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rx_pop    = rx_pop_s;
    assign tx_push   = tx_push_s;
    assign tx_data   = tx_byte_s;

    assign htrans    = (state_q == ST_BUS_A) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr     = addr_q & ADDR_ALIGN_MASK;
    assign hwrite    = (state_q == ST_BUS_A) && is_wr_q;
    assign hwdata    = ((state_q == ST_BUS_D) && is_wr_q) ? data_q : '0;
    assign hsize     = HSIZE_WORD;
    assign hburst    = HBURST_SINGLE;
    assign hmastlock = 1'b0;
    assign hprot     = HPROT_DATA_PRIV;

endmodule

// File: doc/uart_hasti_bridge.md
Name: uart_hasti_bridge

Overview:
Debug and loader bus master that turns a byte stream received from the UART into single-word HASTI transfers, and returns the results as a byte stream.
It is the initiator counterpart to the UART/peripheral HASTI slaves. Software on the host can peek and poke any slave, including memory and the UART registers, without the core running.
Byte side connects to the UART byte FIFOs (pop-RX / push-TX); bus side is a HASTI master port into the arbiter.

Parameters:
TIMEOUT_CYCLES, 1000000, inter-byte timeout within a partial command in clk cycles; 0 disables the timeout.
ACK_BYTE, 8'hA5, response byte for a successful write.
ERR_BYTE, 8'hEE, response byte for any bus error (hresp=1).

Ports:
clk  in  1  system clock
resetn  in  1  reset, asynchronous, active-low
rx_data  in  8  received byte at head of RX FIFO
rx_valid  in  1  RX FIFO non-empty
rx_pop  out  1  consume rx_data this cycle
tx_data  out  8  byte to transmit
tx_push  out  1  write tx_data to TX FIFO this cycle
tx_full  in  1  TX FIFO full
haddr  out  `HASTI_ADDR_WIDTH  transfer address, word-aligned
hwrite  out  1  1=write
hsize  out  `HASTI_SIZE_WIDTH  constant 3'b010 (word)
hburst  out  `HASTI_BURST_WIDTH  constant SINGLE (0)
hmastlock  out  1  constant 0
hprot  out  `HASTI_PROT_WIDTH  constant 4'b0011 (data, privileged)
htrans  out  `HASTI_TRANS_WIDTH  IDLE (2'b00) or NONSEQ (2'b10)
hwdata  out  `HASTI_BUS_WIDTH  write data, valid in data phase
hrdata  in  `HASTI_BUS_WIDTH  read data
hready  in  1  slave ready
hresp  in  1  slave error (1=ERROR)

Behaviour:
- Reset is asynchronous, active-low. Clock and reset ports are named clk and resetn. On reset: state=IDLE, htrans=IDLE, haddr=0, hwrite=0, hwdata=0, rx_pop=0, tx_push=0, tx_data=0, all counters=0.
- Command frame:
  - Write: 8'h01, then addr b0..b3 (LE), then data b0..b3 (LE). Response is ACK_BYTE or ERR_BYTE.
  - Read: 8'h02, then addr b0..b3 (LE). Response is data b0..b3 (LE), or a single ERR_BYTE.
- Any other command byte is popped and discarded; the bridge stays in IDLE and sends no response.
- rx_pop is asserted for one cycle per consumed byte, only when rx_valid=1 in an RX-consuming state. It is never asserted in bus or response states, so bytes arriving during those states wait in the FIFO.
- States:
  - IDLE: wait for a command byte, then go to ADDR.
  - ADDR: receive 4 address bytes via a 2-bit byte counter. Go to WDATA if the command is write, else BUS_A.
  - WDATA: receive 4 data bytes, then go to BUS_A.
  - BUS_A: drive htrans=NONSEQ, haddr={addr[31:2],2'b00}, hwrite. When hready=1, go to BUS_D and drop htrans to IDLE in the same edge.
  - BUS_D: drive hwdata (writes). When hready=1, capture hrdata (reads) and hresp into the error flag, then go to RESP.
  - RESP: push the response bytes, one per cycle, only when tx_full=0. tx_data is driven together with tx_push. After the last byte, return to IDLE.
- Transfer latency: minimum 2 cycles from BUS_A entry to RESP (zero-wait slave). With an N-wait slave the bus phase takes N extra cycles; there is no bus timeout.
- hresp=1 is sampled on the hready=1 cycle of the data phase. The error flag is cleared on entry to BUS_A.
- Timeout counter:
  - Counts only in ADDR and WDATA. It resets to 0 on every popped byte and on state entry.
  - When it reaches TIMEOUT_CYCLES-1 with no byte popped, go to IDLE silently, discarding the partial frame.
  - A byte popped in the same cycle as expiry wins: no timeout.
  - TIMEOUT_CYCLES=0 disables the counter.
- Address bits [1:0] are ignored and the forced-zero value is the one driven on haddr.
- tx_full held high stalls RESP indefinitely; no bytes are dropped or duplicated.
- Reset mid-transfer aborts immediately; the bus is not completed. This is acceptable for a debug master.

Decomposition:
- Shared package/header: HTRANS encodings (IDLE=2'b00, NONSEQ=2'b10), HSIZE_WORD, HBURST_SINGLE, command codes CMD_WR=8'h01 and CMD_RD=8'h02. These use the existing `HASTI_*_WIDTH defines.
- Single module. The byte shift registers for address and data and the timeout counter are inline; no sub-module is needed.

Test Plan:
- Write: send 01 10 00 00 00 EF BE AD DE with a zero-wait slave -> one NONSEQ at haddr=32'h00000010, hwrite=1, hsize=3'b010; hwdata=32'hDEADBEEF in the next cycle; TX receives A5.
- Read: slave returns 32'h12345678 at addr 32'h00000020 with 2 wait states -> htrans NONSEQ for 1 cycle, BUS_D held 3 cycles; TX receives 78 56 34 12.
- Error: send read 02 00 00 00 80; slave asserts hresp=1 in the data phase -> TX receives the single byte EE; a following valid write returns A5 (error flag cleared).
- Timeout: TIMEOUT_CYCLES=16; send 01 10 00 then nothing for 16 cycles -> state returns to IDLE with no bus transfer and no TX. A subsequent full read frame completes normally.
- Back-pressure: tx_full=1 held for 50 cycles during a read response -> tx_push stays 0. After release, exactly 4 bytes are pushed in order with no duplicates.
- Unaligned/garbage: send 7F, then read 02 23 00 00 00 -> 7F is discarded with no TX; the read is issued at haddr=32'h00000020.
